pa_lane_drr_scheduler: RTL and testbench
========================================

# pa_lane_drr_scheduler

Deficit-round-robin scheduler that decides which ingress lane's ticket the page allocator services next. It watches per-lane "ticket available" requests and their packet lengths, grants one lane at a time, and holds that grant until the allocator reports the packet written. It replenishes per-lane credit by a fixed quantum and signals each replenishment on `quantum_update`. It sits between the per-lane ticket FIFOs and the page allocator's ticket-read front end.

## Interface
Parameters:
- `N_LANE`, 4, number of ingress lanes (power of two, ≥2)
- `LANE_W`, 2, $clog2(N_LANE)
- `LEN_W`, 8, packet length width (matches MAX_PKT_LENGTH_BITS)
- `DEFICIT_W`, 10, per-lane deficit counter width
- `QUANTUM`, 128, credit added per lane visit (1 ≤ QUANTUM < 2^DEFICIT_W)

Ports:
- `clk` in 1: single clock, all logic rising-edge
- `rst` in 1: synchronous, active-high reset
- `sched_en` in 1: when low, the scheduler holds in SCAN without advancing or crediting
- `lane_req_valid` in N_LANE: lane has a ticket at its head
- `lane_req_len_flat` in N_LANE*LEN_W: head-ticket length per lane, stable while its valid is high
- `grant_valid` out 1: offer of one lane to the allocator
- `grant_ready` in 1: allocator accepts the offer
- `grant_lane` out LANE_W: offered lane index
- `grant_len` out LEN_W: latched length of offered ticket
- `pkt_done` in 1: single-cycle pulse, allocator finished the granted packet
- `quantum_update` out N_LANE: one-cycle pulse on lane whose deficit was credited
- `sched_busy` out 1: high in OFFER or BUSY
- `deficit_flat` out N_LANE*DEFICIT_W: current deficits, for observability

## Operation
- State: `rr_ptr` (LANE_W), `credited` (1 bit), `deficit[N_LANE]`, FSM {SCAN, OFFER, BUSY}.
- SCAN, lane p = rr_ptr, sched_en = 1:
  - !valid[p]: deficit[p] ← 0, rr_ptr ← p+1 (wraps N_LANE-1 → 0), credited ← 0.
  - valid[p], credited = 0: deficit[p] ← min(deficit[p]+QUANTUM, 2^DEFICIT_W-1), quantum_update[p] pulses, credited ← 1.
  - valid[p], credited = 1, deficit[p] ≥ len[p]: latch grant_lane=p and grant_len=len[p], go to OFFER.
  - valid[p], credited = 1, deficit[p] < len[p]: rr_ptr ← p+1, credited ← 0.
- OFFER: grant_valid = 1. On grant_ready: deficit[p] ← deficit[p] − grant_len (never underflows), go to BUSY.
- BUSY: on pkt_done go to SCAN with rr_ptr and credited unchanged, so the same lane can be served again in the same visit.
- pkt_done outside BUSY, or in the acceptance cycle, is ignored.
- Length 0 tickets are legal: they are granted with no deficit change.
- A requester dropping valid while in OFFER/BUSY does not withdraw the grant. This is a protocol violation and is flagged by a bench assertion.

## Timing
- Reset values: grant_valid 0, grant_lane 0, grant_len 0, quantum_update 0, sched_busy 0, all deficits 0, rr_ptr 0, credited 0, FSM SCAN.
- Skipping an empty lane costs 1 cycle.
- Credit costs 1 cycle and the deficit check costs 1 cycle. A freshly visited valid lane therefore asserts grant_valid 2 cycles after rr_ptr reaches it.
- A re-grant after pkt_done asserts grant_valid 2 cycles after the pkt_done cycle: 1 cycle back to SCAN, 1 cycle to check.
- grant_lane and grant_len are registered, stable for the whole of OFFER and BUSY, and only change on entry to OFFER.
- Deficit update is visible on deficit_flat the cycle after acceptance.
- rst asserted in any state returns everything to reset values on the next edge. An in-flight grant is abandoned.
- sched_en = 0 freezes SCAN only. OFFER and BUSY complete normally.

## Test plan
- Lane 0 only valid, len 100. Expected: quantum_update[0] at cycle 1 after reset release, grant lane 0 len 100 at cycle 2. On accept, deficit0 = 28. After pkt_done, 28 < 100 advances the pointer; lanes 1-3 are skipped; lane 0 is re-credited to 156 and re-granted; deficit0 = 56.
- All lanes valid, len 64, grant_ready = 1, pkt_done 3 cycles after each accept → grant order 0,0,1,1,2,2,3,3,0,… and every deficit returns to 0 after each visit.
- Lane 1 only, len 200 → first visit: credit to 128, no grant. Second visit: credit to 256, grant len 200, deficit1 = 56.
- Lane 2 holds deficit 56 and is deasserted before its next scan → deficit2 cleared to 0 on the skip cycle, with no quantum_update[2] pulse.
- grant_ready held low for 20 cycles → grant_valid, grant_lane and grant_len stay constant and no deficit changes. A pkt_done pulse during OFFER is ignored.
- rst asserted for 1 cycle while in BUSY with deficit0 = 28 → next cycle all outputs are at reset values and deficit_flat = 0. A subsequent pkt_done is ignored and scanning restarts at lane 0.

Source files
------------

// File: rtl/pa_lane_drr_scheduler.sv
// pa_lane_drr_scheduler: deficit-round-robin lane arbiter feeding the page allocator ticket reader
module pa_lane_drr_scheduler #(
    parameter int N_LANE    = 4,
    parameter int LANE_W    = 2,
    parameter int LEN_W     = 8,
    parameter int DEFICIT_W = 10,
    parameter int QUANTUM   = 128
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sched_en,
    input  logic [N_LANE-1:0]             lane_req_valid,
    input  logic [N_LANE*LEN_W-1:0]       lane_req_len_flat,
    output logic                          grant_valid,
    input  logic                          grant_ready,
    output logic [LANE_W-1:0]             grant_lane,
    output logic [LEN_W-1:0]              grant_len,
    input  logic                          pkt_done,
    output logic [N_LANE-1:0]             quantum_update,
    output logic                          sched_busy,
    output logic [N_LANE*DEFICIT_W-1:0]   deficit_flat
);
    typedef enum logic [1:0] {SCAN, OFFER, BUSY} state_t;
    state_t                 state;
    logic [LANE_W-1:0]      rr_ptr;
    logic                   credited;
    logic [DEFICIT_W-1:0]   deficit [N_LANE];
    logic [LEN_W-1:0]       len [N_LANE];
    logic [LEN_W-1:0]       cur_len;
    logic [DEFICIT_W-1:0]   cur_def;
    logic [DEFICIT_W:0]     raw_sum;
    logic [DEFICIT_W-1:0]   credit_sum;
    // Unpack lane lengths, pack deficits, and form the saturating credit for the lane under the pointer
    always_comb begin
        for (int i = 0; i < N_LANE; i++) begin
            len[i] = lane_req_len_flat[i*LEN_W +: LEN_W];
            deficit_flat[i*DEFICIT_W +: DEFICIT_W] = deficit[i];
        end
        cur_len    = len[rr_ptr];
        cur_def    = deficit[rr_ptr];
        raw_sum    = {1'b0, cur_def} + (DEFICIT_W+1)'(QUANTUM);
        credit_sum = raw_sum[DEFICIT_W] ? '1 : raw_sum[DEFICIT_W-1:0];
    end
    assign grant_valid = state == OFFER;
    assign sched_busy  = state != SCAN;
    // Scan/credit/check one lane per cycle; hold the grant through OFFER and BUSY
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= SCAN;
            rr_ptr         <= '0;
            credited       <= 1'b0;
            grant_lane     <= '0;
            grant_len      <= '0;
            quantum_update <= '0;
            for (int i = 0; i < N_LANE; i++) deficit[i] <= '0;
        end else begin
            quantum_update <= '0;
            case (state)
                SCAN: if (sched_en) begin
                    if (!lane_req_valid[rr_ptr]) begin
                        deficit[rr_ptr] <= '0;
                        rr_ptr          <= rr_ptr + LANE_W'(1);
                        credited        <= 1'b0;
                    end else if (!credited) begin
                        deficit[rr_ptr]        <= credit_sum;
                        quantum_update[rr_ptr] <= 1'b1;
                        credited               <= 1'b1;
                    end else if (cur_def >= DEFICIT_W'(cur_len)) begin
                        grant_lane <= rr_ptr;
                        grant_len  <= cur_len;
                        state      <= OFFER;
                    end else begin
                        rr_ptr   <= rr_ptr + LANE_W'(1);
                        credited <= 1'b0;
                    end
                end
                OFFER: if (grant_ready) begin
                    deficit[grant_lane] <= deficit[grant_lane] - DEFICIT_W'(grant_len);
                    state               <= BUSY;
                end
                BUSY: if (pkt_done) state <= SCAN;
                default: state <= SCAN;
            endcase
        end
    end
endmodule

// File: tb/tb_pa_lane_drr_scheduler.sv
// tb_pa_lane_drr_scheduler: directed checks of the DRR scheduler against a behavioural model
module tb_pa_lane_drr_scheduler;
    localparam int N = 4, LW = 8, DW = 10, Q = 128, DMAX = 1023;
    logic          clk = 0, rst = 1, sched_en = 1, grant_ready = 0, pkt_done = 0;
    logic [N-1:0]  lane_req_valid = '0;
    logic [N*LW-1:0] lane_req_len_flat = '0;
    logic          grant_valid, sched_busy;
    logic [1:0]    grant_lane;
    logic [LW-1:0] grant_len;
    logic [N-1:0]  quantum_update;
    logic [N*DW-1:0] deficit_flat;
    int tests = 0, fails = 0;

    pa_lane_drr_scheduler #(.N_LANE(N), .LANE_W(2), .LEN_W(LW), .DEFICIT_W(DW), .QUANTUM(Q)) dut (
        .clk(clk), .rst(rst), .sched_en(sched_en), .lane_req_valid(lane_req_valid),
        .lane_req_len_flat(lane_req_len_flat), .grant_valid(grant_valid), .grant_ready(grant_ready),
        .grant_lane(grant_lane), .grant_len(grant_len), .pkt_done(pkt_done),
        .quantum_update(quantum_update), .sched_busy(sched_busy), .deficit_flat(deficit_flat));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int dval(input int l);
        return int'(deficit_flat[l*DW +: DW]);
    endfunction

    // Behavioural model: deficits as plain integers, lane walk as modular arithmetic
    int   m_def [N];
    int   m_ptr, m_gl, m_glen, m_len;
    bit   m_cred, m_live;
    int   m_mode;
    logic [N-1:0]    m_qu;
    logic [N*DW-1:0] m_flat;
    always @(posedge clk) begin
        if (rst) begin
            foreach (m_def[i]) m_def[i] = 0;
            m_ptr = 0; m_cred = 0; m_mode = 0; m_gl = 0; m_glen = 0; m_qu = '0; m_live = 1;
        end else begin
            m_qu = '0;
            if (m_mode == 0) begin
                if (sched_en) begin
                    m_len = int'(lane_req_len_flat[m_ptr*LW +: LW]);
                    if (!lane_req_valid[m_ptr]) begin
                        m_def[m_ptr] = 0; m_ptr = (m_ptr + 1) % N; m_cred = 0;
                    end else if (!m_cred) begin
                        m_def[m_ptr] = (m_def[m_ptr] + Q > DMAX) ? DMAX : m_def[m_ptr] + Q;
                        m_qu[m_ptr] = 1'b1; m_cred = 1;
                    end else if (m_def[m_ptr] >= m_len) begin
                        m_gl = m_ptr; m_glen = m_len; m_mode = 1;
                    end else begin
                        m_ptr = (m_ptr + 1) % N; m_cred = 0;
                    end
                end
            end else if (m_mode == 1) begin
                if (grant_ready) begin m_def[m_gl] = m_def[m_gl] - m_glen; m_mode = 2; end
            end else if (pkt_done) m_mode = 0;
        end
        #1;
        if (m_live) begin
            for (int i = 0; i < N; i++) m_flat[i*DW +: DW] = DW'(m_def[i]);
            chk("m_grant_valid", grant_valid, m_mode == 1);
            chk("m_sched_busy", sched_busy, m_mode != 0);
            chk("m_grant_lane", grant_lane, m_gl);
            chk("m_grant_len", grant_len, m_glen);
            chk("m_quantum_update", quantum_update, m_qu);
            chk("m_deficit_flat", deficit_flat, m_flat);
        end
    end

    // The granted lane must keep its request up until the packet is done
    always @(posedge clk)
        if (!rst && sched_busy)
            assert (lane_req_valid[grant_lane]) else $error("granted lane %0d dropped its request", grant_lane);

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input logic [N-1:0] v, input logic [N*LW-1:0] l);
        @(negedge clk);
        rst = 1; lane_req_valid = v; lane_req_len_flat = l;
        grant_ready = 0; pkt_done = 0; sched_en = 1;
        tick();
        rst = 0;
    endtask

    task automatic wait_grant(input int maxc);
        int n = 0;
        while (!grant_valid && n < maxc) begin tick(); n++; end
        if (!grant_valid) chk("grant_timeout", 0, 1);
    endtask

    task automatic accept();
        grant_ready = 1; tick(); grant_ready = 0;
    endtask

    task automatic pulse_done();
        pkt_done = 1; tick(); pkt_done = 0;
    endtask

    task automatic run_long(input int l);
        logic [N*LW-1:0] lens = '0;
        lens[l*LW +: LW] = 8'd200;
        do_reset(4'b1 << l, lens);
        wait_grant(40);
        chk("long_lane", grant_lane, l);
        chk("long_len", grant_len, 200);
        chk("long_def_credit2", dval(l), 256);
        accept();
        chk("long_def_after", dval(l), 56);
    endtask

    initial begin
        int order [9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
        // single lane, length 100
        do_reset(4'b0001, {24'd0, 8'd100});
        tick();
        chk("t1_qu_cycle1", quantum_update, 4'b0001);
        tick();
        chk("t1_grant_cycle2", grant_valid, 1);
        chk("t1_lane", grant_lane, 0);
        chk("t1_len", grant_len, 100);
        accept();
        chk("t1_def28", dval(0), 28);
        tick(2);
        pulse_done();
        wait_grant(20);
        chk("t1_def156", dval(0), 156);
        accept();
        chk("t1_def56", dval(0), 56);
        tick(); pulse_done();
        // all lanes, length 64, ready held high
        do_reset(4'b1111, {4{8'd64}});
        grant_ready = 1;
        for (int i = 0; i < 9; i++) begin
            wait_grant(20);
            chk("t2_order", grant_lane, order[i]);
            if (i == 8) chk("t2_def_fresh", dval(0), 128);
            tick(3);
            pulse_done();
        end
        grant_ready = 0;
        // long packet on lane 1 needs two visits
        run_long(1);
        tick(); pulse_done();
        // lane 2 builds deficit 56, then drops its request
        run_long(2);
        tick(); pulse_done();
        lane_req_valid = '0;
        tick();
        chk("t4_def2_cleared", dval(2), 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("t4_no_qu", quantum_update, 0);
            chk("t4_no_grant", grant_valid, 0);
        end
        // grant held while ready is low; stray pkt_done and sched_en drop ignored in OFFER
        do_reset(4'b1000, {8'd10, 24'd0});
        wait_grant(20);
        for (int i = 0; i < 20; i++) begin
            pkt_done = (i == 5);
            if (i == 10) sched_en = 0;
            tick();
            chk("t5_hold_valid", grant_valid, 1);
            chk("t5_hold_lane", grant_lane, 3);
            chk("t5_hold_len", grant_len, 10);
            chk("t5_hold_def", dval(3), 128);
        end
        pkt_done = 0;
        accept();
        chk("t5_def118", dval(3), 118);
        tick(); pulse_done();
        for (int i = 0; i < 5; i++) begin tick(); chk("t5_frozen", grant_valid, 0); end
        sched_en = 1;
        tick();
        chk("t5_resume_grant", grant_valid, 1);
        accept();
        chk("t5_def108", dval(3), 108);
        tick(); pulse_done();
        chk("t5_regrant_gap", grant_valid, 0);
        tick();
        chk("t5_regrant", grant_valid, 1);
        // reset while busy
        do_reset(4'b0001, {24'd0, 8'd100});
        wait_grant(10);
        accept();
        chk("t6_def28", dval(0), 28);
        tick();
        rst = 1; tick(); rst = 0;
        chk("t6_rst_gv", grant_valid, 0);
        chk("t6_rst_lane", grant_lane, 0);
        chk("t6_rst_len", grant_len, 0);
        chk("t6_rst_qu", quantum_update, 0);
        chk("t6_rst_busy", sched_busy, 0);
        chk("t6_rst_def", deficit_flat, 0);
        pulse_done();
        chk("t6_restart_lane0", quantum_update, 4'b0001);
        chk("t6_done_ignored", sched_busy, 0);
        tick(3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "watchdog");
    end
endmodule
